// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg: FSM encoding and datapath widths shared by mult_arbiter
package mult_arbiter_pkg;
  localparam int OPW = 3;
  localparam int PW = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one external multiplier between two requesters
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic [OPW-1:0] a0,
  input  logic [OPW-1:0] b0,
  input  logic [OPW-1:0] a1,
  input  logic [OPW-1:0] b1,
  output logic           ack0,
  output logic           ack1,
  output logic [PW-1:0]  result,
  output logic           err,
  output logic           busy,
  output logic           mul_start,
  output logic [OPW-1:0] mul_a,
  output logic [OPW-1:0] mul_b,
  input  logic           mul_done,
  input  logic [PW-1:0]  mul_product
);
  state_t state, state_n;
  logic rr, gnt, pick, expired;
  logic [3:0] timer;
  // rr only breaks ties; a lone request always wins
  assign pick = (req0 && req1) ? rr : req1;
  assign expired = timer == 4'(TIMEOUT);
  assign busy = state != IDLE;
  assign mul_start = state == LAUNCH;
  assign ack0 = state == RESP && !gnt;
  assign ack1 = state == RESP && gnt;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = (req0 || req1) ? LAUNCH : IDLE;
      LAUNCH:  state_n = WAIT;
      WAIT:    state_n = (mul_done || expired) ? RESP : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk)
    if (rst) begin
      rr     <= 1'b0;
      gnt    <= 1'b0;
      timer  <= '0;
      result <= '0;
      err    <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        gnt   <= pick;
        mul_a <= pick ? a1 : a0;
        mul_b <= pick ? b1 : b0;
      end
      if (state == LAUNCH) timer <= '0;
      if (state == WAIT) begin
        if (mul_done) begin
          result <= mul_product;
          err    <= 1'b0;
        end else if (expired) begin
          result <= '0;
          err    <= 1'b1;
        end else timer <= timer + 4'd1;
      end
      if (state == RESP) rr <= ~gnt;
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed and randomized checks of mult_arbiter against a transaction-timing model
module tb_mult_arbiter;
  localparam int TO = 6;
  logic clk = 0, rst = 1, req0 = 0, req1 = 0, spur = 0;
  logic [2:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic ack0, ack1, err, busy, mul_start, mul_done;
  logic [2:0] mul_a, mul_b;
  logic [5:0] result, mul_product, prod;
  int cnt, lat;
  int errs = 0, checks = 0, cyc = 0, lat_force = -1;
  bit rnd = 0, s0 = 0, s1 = 0;
  bit m_busy = 0, m_err = 0, t_err = 0, m_rr = 0, g = 0;
  logic [5:0] m_res = 0, t_res = 0;
  logic [2:0] ta = 0, tb = 0;
  int gcyc = -10, ack_at = -10, w0 = 0, w1 = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .result(result), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  // engine: done pulses lat-1 cycles after the start cycle; lat 0 never finishes
  always @(posedge clk)
    if (rst) begin
      cnt  <= 0;
      prod <= 0;
    end else if (mul_start) begin
      cnt  <= lat > 0 ? lat - 1 : 0;
      prod <= 6'(mul_a) * 6'(mul_b);
    end else if (cnt > 0) cnt <= cnt - 1;
  assign mul_done = cnt == 1 || spur;
  assign mul_product = prod;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // consumes the inputs sampled at this edge; a transaction's whole timeline is fixed at grant
  task automatic advance();
    int v;
    if (rst) begin
      m_busy = 0; m_res = 0; m_err = 0; m_rr = 0;
    end else if (m_busy) begin
      if (cyc == ack_at) begin m_busy = 0; m_rr = !g; end
    end else if (req0 || req1) begin
      g = (req0 && req1) ? m_rr : req1;
      ta = g ? a1 : a0;
      tb = g ? b1 : b0;
      v = lat_force >= 0 ? lat_force : int'($urandom_range(0, TO + 4));
      lat = v; gcyc = cyc; m_busy = 1;
      if (v >= 2 && v <= TO + 2) begin
        ack_at = cyc + v + 1; t_res = 6'(ta) * 6'(tb); t_err = 0;
      end else begin
        ack_at = cyc + TO + 3; t_res = 0; t_err = 1;
      end
    end
  endtask

  task automatic check_cycle();
    bit fin;
    fin = m_busy && cyc == ack_at;
    if (fin) begin m_res = t_res; m_err = t_err; end
    check("ack0", 8'(ack0), 8'(fin && !g));
    check("ack1", 8'(ack1), 8'(fin && g));
    check("busy", 8'(busy), 8'(m_busy));
    check("mul_start", 8'(mul_start), 8'(m_busy && cyc == gcyc + 1));
    check("result", 8'(result), 8'(m_res));
    check("err", 8'(err), 8'(m_err));
    if (m_busy) check("operands", 8'({mul_a, mul_b}), 8'({ta, tb}));
    if (ack1 && req0) begin w0++; check("fair0", 8'(w0 <= 1), 8'(1)); end
    if (ack0 && req1) begin w1++; check("fair1", 8'(w1 <= 1), 8'(1)); end
    if (ack0 || !req0 || rst) w0 = 0;
    if (ack1 || !req1 || rst) w1 = 0;
    s0 = ack0; s1 = ack1;
  endtask

  task automatic agents();
    if (s0) req0 = $urandom % 4 == 0;
    else if (!req0 && $urandom % 3 == 0) begin a0 = 3'($urandom); b0 = 3'($urandom); req0 = 1; end
    else if (req0 && $urandom % 50 == 0) req0 = 0;
    if (s1) req1 = $urandom % 4 == 0;
    else if (!req1 && $urandom % 3 == 0) begin a1 = 3'($urandom); b1 = 3'($urandom); req1 = 1; end
    else if (req1 && $urandom % 50 == 0) req1 = 0;
    rst = $urandom % 150 == 0;
    spur = (!m_busy || cyc == gcyc + 1 || cyc == ack_at) && $urandom % 5 == 0;
  endtask

  task automatic step();
    @(posedge clk);
    advance();
    cyc++;
    #1;
    if (rnd) agents();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic wait_ack(output int k);
    k = -1;
    for (int i = 0; i < 60 && k < 0; i++) begin
      step();
      k = ack0 ? 0 : ack1 ? 1 : -1;
    end
    if (k < 0) check("ack_seen", 8'(ack0 | ack1), 8'(1));
  endtask

  initial begin
    int k, c0;
    repeat (2) step();
    check("rst_ops", 8'({mul_a, mul_b}), 8'(0));
    rst = 0;
    // single request, engine latency 2
    lat_force = 2; a0 = 5; b0 = 3; req0 = 1; c0 = cyc;
    step();
    check("start_at_1", 8'(mul_start), 8'(1));
    wait_ack(k);
    check("lat_single", 8'(cyc - c0), 8'(3));
    check("who_single", 8'(k), 8'(0));
    check("res_15", 8'(result), 8'(15));
    check("err_single", 8'(err), 8'(0));
    req0 = 0;
    // contention with both held: alternation from rr=0
    rst = 1; step(); rst = 0;
    a0 = 7; b0 = 7; a1 = 2; b1 = 3; req0 = 1; req1 = 1;
    wait_ack(k);
    check("who_first", 8'(k), 8'(0));
    check("res_49", 8'(result), 8'(49));
    wait_ack(k);
    check("who_second", 8'(k), 8'(1));
    check("res_6", 8'(result), 8'(6));
    wait_ack(k);
    check("who_third", 8'(k), 8'(0));
    check("res_49b", 8'(result), 8'(49));
    req0 = 0; req1 = 0;
    repeat (2) step();
    spur = 1; step(); spur = 0; step();
    check("spur_idle", 8'(result), 8'(49));
    // timeout
    lat_force = 0; a1 = 6; b1 = 0; req1 = 1; c0 = cyc;
    wait_ack(k);
    check("who_to", 8'(k), 8'(1));
    check("lat_to", 8'(cyc - c0), 8'(TO + 3));
    check("res_to", 8'(result), 8'(0));
    check("err_to", 8'(err), 8'(1));
    req1 = 0;
    step();
    check("busy_after_to", 8'(busy), 8'(0));
    // reset during WAIT then a late done
    lat_force = 3; a0 = 2; b0 = 2; req0 = 1;
    repeat (2) step();
    rst = 1; step();
    rst = 0; req0 = 0; spur = 1;
    check("rst_busy", 8'(busy), 8'(0));
    check("rst_err", 8'(err), 8'(0));
    check("rst_mul_a", 8'(mul_a), 8'(0));
    step(); spur = 0;
    check("late_done_ack", 8'({ack0, ack1}), 8'(0));
    check("late_done_res", 8'(result), 8'(0));
    repeat (3) step();
    lat_force = 2; a0 = 3; b0 = 3; req0 = 1;
    wait_ack(k);
    check("who_after_rst", 8'(k), 8'(0));
    check("res_9", 8'(result), 8'(9));
    req0 = 0;
    step();
    // randomized traffic
    lat_force = -1; rnd = 1;
    repeat (3000) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
